fetch_unit: RTL and testbench

Instruction fetch stage of the 8-bit processor. Owns the 10-bit program counter, drives the address of the 1k x 14-bit combinational program ROM, and captures the returned word into an instruction register with a valid flag for the decode stage. Handles stalls, jump/branch redirects, a small hardware return-address stack for call/return, and halt.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// fetch_unit : instruction fetch stage with PC, instruction register and
//              return-address stack.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned INSTR_W   = 14,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               stall,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               jump_call,
    input  logic               ret_valid,
    input  logic               halt,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    output logic               halted,
    output logic               ras_overflow,
    output logic               ras_underflow
);

    localparam int unsigned SP_W = $clog2(RAS_DEPTH);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_pc_one   = ADDR_W'(1);
    localparam logic [SP_W-1:0]   c_sp_one   = SP_W'(1);
    localparam logic [SP_W:0]     c_cnt_one  = (SP_W + 1)'(1);
    localparam logic [SP_W:0]     c_ras_full = (SP_W + 1)'(RAS_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [SP_W-1:0]   r_sp;      // next write slot; top of stack is r_sp-1
    logic [SP_W:0]     r_count;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

    logic [SP_W-1:0]   w_top_idx;
    logic [ADDR_W-1:0] w_ret_addr;

    assign rom_addr   = r_pc;
    assign halted     = (r_state == ST_HALT);
    assign w_top_idx  = r_sp - c_sp_one;
    assign w_ret_addr = ir_pc + c_pc_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_pc          <= c_reset_pc;
            r_sp          <= '0;
            r_count       <= '0;
            ir            <= '0;
            ir_pc         <= '0;
            ir_valid      <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt) begin
                        r_state  <= ST_HALT;
                        ir_valid <= 1'b0;
                    end else if (jump_valid) begin
                        r_pc     <= jump_target;
                        ir_valid <= 1'b0;
                        if (jump_call) begin
                            // Circular storage: when full, the write slot is the oldest entry.
                            r_ras[r_sp] <= w_ret_addr;
                            r_sp        <= r_sp + c_sp_one;
                            if (r_count == c_ras_full) begin
                                ras_overflow <= 1'b1;
                            end else begin
                                r_count <= r_count + c_cnt_one;
                            end
                        end
                    end else if (ret_valid) begin
                        ir_valid <= 1'b0;
                        if (r_count == '0) begin
                            r_pc          <= c_reset_pc;
                            ras_underflow <= 1'b1;
                        end else begin
                            r_pc    <= r_ras[w_top_idx];
                            r_sp    <= w_top_idx;
                            r_count <= r_count - c_cnt_one;
                        end
                    end else if (!stall) begin
                        ir       <= rom_data;
                        ir_pc    <= r_pc;
                        ir_valid <= 1'b1;
                        r_pc     <= r_pc + c_pc_one;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_fetch_unit : directed and random stimulus against a queue-based model.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    localparam int ADDR_W    = 10;
    localparam int INSTR_W   = 14;
    localparam int RESET_PC  = 0;
    localparam int RAS_DEPTH = 4;
    localparam int PC_MOD    = 1 << ADDR_W;

    logic               clk;
    logic               rst_n;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               stall;
    logic               jump_valid;
    logic [ADDR_W-1:0]  jump_target;
    logic               jump_call;
    logic               ret_valid;
    logic               halt;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic               halted;
    logic               ras_overflow;
    logic               ras_underflow;

    logic [INSTR_W-1:0] rom [PC_MOD];

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .stall        (stall),
        .jump_valid   (jump_valid),
        .jump_target  (jump_target),
        .jump_call    (jump_call),
        .ret_valid    (ret_valid),
        .halt         (halt),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .halted       (halted),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_pc, m_ir, m_ir_pc;
    bit m_valid, m_halted, m_ovf, m_unf;
    int stk[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rom_addr"}, 32'(rom_addr), 32'(m_pc));
        check({tag, ".ir"}, 32'(ir), 32'(m_ir));
        check({tag, ".ir_pc"}, 32'(ir_pc), 32'(m_ir_pc));
        check({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_valid));
        check({tag, ".halted"}, 32'(halted), 32'(m_halted));
        check({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
        check({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_ir = 0; m_ir_pc = 0;
        m_valid = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
        stk.delete();
    endtask

    task automatic step(input string tag, input bit s, input bit jv, input bit jc,
                        input bit rv, input bit h, input int jt);
        stall = s; jump_valid = jv; jump_call = jc; ret_valid = rv; halt = h;
        jump_target = ADDR_W'(jt);
        @(posedge clk);
        if (!m_halted) begin
            if (h) begin
                m_halted = 1; m_valid = 0;
            end else if (jv) begin
                if (jc) begin
                    stk.push_back((m_ir_pc + 1) % PC_MOD);
                    if (stk.size() > RAS_DEPTH) begin
                        void'(stk.pop_front());
                        m_ovf = 1;
                    end
                end
                m_pc = jt % PC_MOD; m_valid = 0;
            end else if (rv) begin
                if (stk.size() == 0) begin
                    m_pc = RESET_PC; m_unf = 1;
                end else begin
                    m_pc = stk.pop_back();
                end
                m_valid = 0;
            end else if (!s) begin
                m_ir = int'(rom[m_pc]); m_ir_pc = m_pc; m_valid = 1;
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input string tag, input int jt, input bit jc);
        step(tag, 0, 1, jc, 0, 0, jt);
    endtask

    initial begin
        for (int i = 0; i < PC_MOD; i++) rom[i] = INSTR_W'($urandom);
        rst_n = 1'b0; stall = 0; jump_valid = 0; jump_call = 0;
        ret_valid = 0; halt = 0; jump_target = '0;
        model_reset();
        #12;
        check_all("reset");
        #1 rst_n = 1'b1;

        // Free run from reset
        for (int i = 0; i < 4; i++) run("free");
        check("free.ir_pc3", 32'(ir_pc), 32'd3);
        run("free"); run("free");
        check("stall.at5", 32'(ir_pc), 32'd5);
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 0, 0, 0);
        run("unstall");
        check("unstall.ir_pc6", 32'(ir_pc), 32'd6);
        run("pre_jump");
        // Jump overrides stall
        step("jump_stall", 1, 1, 0, 0, 0, 'h200);
        run("jump_fetch");
        check("jump.ir_pc200", 32'(ir_pc), 32'h200);

        // Single call/return
        jump("to10", 'h10, 0); run("at10");
        jump("call100", 'h100, 1); run("in_sub"); run("in_sub");
        step("ret", 0, 0, 0, 1, 0, 0); run("after_ret");
        check("ret.ir_pc11", 32'(ir_pc), 32'h11);

        // Five nested calls then five returns with depth four
        for (int i = 0; i < 5; i++) begin
            jump("ncall", int'($urandom_range(0, PC_MOD - 1)), 1);
            run("ncall_fetch");
        end
        check("nest.ovf", 32'(ras_overflow), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step("nret", 0, 0, 0, 1, 0, 0);
            run("nret_fetch");
        end
        check("nest.unf", 32'(ras_underflow), 32'd1);

        // Random mix: jump has priority over simultaneous return
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step("rand", $urandom_range(0, 4) == 0, r < 10, $urandom_range(0, 1) == 1,
                 (r >= 8 && r < 18), 0, int'($urandom_range(0, PC_MOD - 1)));
        end

        // PC wrap
        jump("to1022", 1022, 0);
        run("wrap"); run("wrap"); run("wrap");
        check("wrap.ir_pc0", 32'(ir_pc), 32'd0);

        // Halt, then everything ignored
        jump("to9", 9, 0); run("at9");
        step("halt", 0, 0, 0, 0, 1, 0);
        check("halt.halted", 32'(halted), 32'd1);
        step("halted_jump", 0, 1, 1, 0, 0, 'h300);
        step("halted_ret", 0, 0, 0, 1, 0, 0);
        run("halted_run");
        check("halt.rom_addr", 32'(rom_addr), 32'd10);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run("restart");
        check("restart.ir_pc2", 32'(ir_pc), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
